// File: rtl/rom_arb_pkg.sv
// Shared encodings for the ROM port arbiter: FSM states, transaction owner
// and memory access size constants.
package rom_arb_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StWait  = 2'b10,
        StDone  = 2'b11
    } state_e;

    // Which requester owns the transaction in flight
    typedef enum logic [1:0] {
        OwnNone = 2'b00,
        OwnI    = 2'b01,
        OwnD    = 2'b10
    } owner_e;

    // Memory access size encodings
    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

    // Default abort threshold for an unanswered memory request
    localparam int unsigned TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Bus bundle for the ROM port arbiter: instruction fetch, data load and the
// shared memory port. The slave modport is the arbiter's view; the master
// modport is the environment (core + memory) view.
interface rom_port_arbiter_if;
    import rom_arb_pkg::*;

    // Instruction fetch side
    logic        i_IREQ;
    logic [31:0] i_IADDR;
    logic        o_IGNT;
    logic [31:0] o_IRDATA;

    // Data load side
    logic        i_DREQ;
    logic [31:0] i_DADDR;
    logic [1:0]  i_DHB;
    logic        o_DGNT;
    logic [31:0] o_DRDATA;

    // Shared error flag, qualifies whichever grant is pulsing
    logic        o_ERR;

    // Memory side
    logic        o_MEM_CE;
    logic        o_MEM_REQ;
    logic [31:0] o_MEM_ADDR;
    logic [1:0]  o_MEM_HB;
    logic        i_MEM_GNT;
    logic [31:0] i_MEM_RDATA;

    modport slave (
        input  i_IREQ, i_IADDR, i_DREQ, i_DADDR, i_DHB, i_MEM_GNT, i_MEM_RDATA,
        output o_IGNT, o_IRDATA, o_DGNT, o_DRDATA, o_ERR,
        output o_MEM_CE, o_MEM_REQ, o_MEM_ADDR, o_MEM_HB
    );

    modport master (
        output i_IREQ, i_IADDR, i_DREQ, i_DADDR, i_DHB, i_MEM_GNT, i_MEM_RDATA,
        input  o_IGNT, o_IRDATA, o_DGNT, o_DRDATA, o_ERR,
        input  o_MEM_CE, o_MEM_REQ, o_MEM_ADDR, o_MEM_HB
    );

endinterface

// File: rtl/rom_arb_pick.sv
// Combinational winner select between instruction fetch and data load.
// Macro ARB_ROUND_ROBIN_EN: ties alternate against the previous owner.
// Without it, data load always wins ties and no history input exists.
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic   ireq,
    input  logic   dreq,
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_e last,
`endif
    output owner_e winner
);

    // Single requester wins outright; a tie is settled by the configured policy
    always_comb begin
        winner = OwnNone;
        if (ireq && dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = (last == OwnI) ? OwnD : OwnI;
`else
            winner = OwnD;
`endif
        end else if (ireq) begin
            winner = OwnI;
        end else if (dreq) begin
            winner = OwnD;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one single-port ROM request port between instruction fetch and data
// load. One transaction in flight; an unanswered memory request is aborted
// after TIMEOUT wait cycles and returned to the owner with an error flag.
// Macro ARB_ROUND_ROBIN_EN selects alternating tie-break instead of
// fixed data-load priority.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic               i_CLK,
    input logic               i_RSTn,
    rom_port_arbiter_if.slave bus
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    state_e          state;
    owner_e          owner;
    owner_e          winner;
    logic [CntW-1:0] count;

    // Registered outputs
    logic        mem_req;
    logic        mem_ce;
    logic [31:0] mem_addr;
    logic [1:0]  mem_hb;
    logic        ignt;
    logic        dgnt;
    logic [31:0] irdata;
    logic [31:0] drdata;
    logic        err;

    // Wait-phase completion: either a grant or the timeout
    logic        wait_end;
    logic [31:0] fin_rdata;
    logic        fin_err;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last;

    rom_arb_pick u_pick (
        .ireq   (bus.i_IREQ),
        .dreq   (bus.i_DREQ),
        .last   (last),
        .winner (winner)
    );
`else
    rom_arb_pick u_pick (
        .ireq   (bus.i_IREQ),
        .dreq   (bus.i_DREQ),
        .winner (winner)
    );
`endif

    // Decide how a WAIT cycle ends; a timed-out read returns zero data
    always_comb begin
        wait_end  = bus.i_MEM_GNT || (count == CntLast);
        fin_err   = !bus.i_MEM_GNT;
        fin_rdata = bus.i_MEM_GNT ? bus.i_MEM_RDATA : 32'h0;
    end

    // Transaction sequencer with registered outputs: IDLE -> ISSUE -> WAIT -> DONE
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state    <= StIdle;
            owner    <= OwnNone;
            count    <= '0;
            mem_req  <= 1'b0;
            mem_ce   <= 1'b0;
            mem_addr <= 32'h0;
            mem_hb   <= HB_BYTE;
            ignt     <= 1'b0;
            dgnt     <= 1'b0;
            irdata   <= 32'h0;
            drdata   <= 32'h0;
            err      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last     <= OwnD;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    // Latch the winner's request so later bus changes are ignored
                    if (winner != OwnNone) begin
                        owner    <= winner;
                        mem_addr <= (winner == OwnI) ? bus.i_IADDR : bus.i_DADDR;
                        mem_hb   <= (winner == OwnI) ? HB_WORD : bus.i_DHB;
                        mem_req  <= 1'b1;
                        mem_ce   <= 1'b1;
                        state    <= StIssue;
                    end
                end
                StIssue: begin
                    mem_req <= 1'b0;
                    count   <= '0;
                    state   <= StWait;
                end
                StWait: begin
                    if (wait_end) begin
                        mem_ce <= 1'b0;
                        ignt   <= (owner == OwnI);
                        dgnt   <= (owner == OwnD);
                        err    <= fin_err;
                        if (owner == OwnI) begin
                            irdata <= fin_rdata;
                        end
                        if (owner == OwnD) begin
                            drdata <= fin_rdata;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last   <= owner;
`endif
                        state  <= StDone;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                StDone: begin
                    ignt  <= 1'b0;
                    dgnt  <= 1'b0;
                    err   <= 1'b0;
                    owner <= OwnNone;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.o_MEM_REQ  = mem_req;
    assign bus.o_MEM_CE   = mem_ce;
    assign bus.o_MEM_ADDR = mem_addr;
    assign bus.o_MEM_HB   = mem_hb;
    assign bus.o_IGNT     = ignt;
    assign bus.o_IRDATA   = irdata;
    assign bus.o_DGNT     = dgnt;
    assign bus.o_DRDATA   = drdata;
    assign bus.o_ERR      = err;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: table-driven single transactions
// plus hand-written tie, timeout and reset sequences.
`timescale 1ns/1ps
module tb_rom_port_arbiter;
    import rom_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rom_port_arbiter_if bus();

    rom_port_arbiter #(.TIMEOUT(15)) dut (
        .i_CLK  (clk),
        .i_RSTn (rst_n),
        .bus    (bus)
    );

    // Simple 1-cycle memory: grants the cycle after it sees o_MEM_REQ
    logic        mem_auto  = 1'b1;
    logic        gnt_auto  = 1'b0;
    logic        gnt_force = 1'b0;
    logic [31:0] mem_data  = 32'h0;
    always @(posedge clk) gnt_auto <= mem_auto && bus.o_MEM_REQ;
    assign bus.i_MEM_GNT   = gnt_auto | gnt_force;
    assign bus.i_MEM_RDATA = mem_data;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [1:0]  dhb;
        logic [31:0] mdata;
        logic        exp_i;
        logic [31:0] exp_addr;
        logic [1:0]  exp_hb;
    } vec_t;

    vec_t vecs[6];

    task automatic wait_issue(input string name);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.o_MEM_REQ && cyc < 20);
        chk(name, 32'(bus.o_MEM_REQ), 32'h1);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int cyc;
        @(negedge clk);
        mem_data    = v.mdata;
        bus.i_IREQ  = v.ireq;
        bus.i_DREQ  = v.dreq;
        bus.i_IADDR = v.iaddr;
        bus.i_DADDR = v.daddr;
        bus.i_DHB   = v.dhb;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.o_MEM_REQ && cyc < 20);
        chk($sformatf("v%0d issue_latency", k), 32'(cyc), 32'd1);
        chk($sformatf("v%0d mem_addr", k), bus.o_MEM_ADDR, v.exp_addr);
        chk($sformatf("v%0d mem_hb", k), 32'(bus.o_MEM_HB), 32'(v.exp_hb));
        chk($sformatf("v%0d mem_ce", k), 32'(bus.o_MEM_CE), 32'h1);
        // Requester changes its bus while pending; latched copy must be kept
        bus.i_IADDR = ~v.iaddr;
        bus.i_DADDR = ~v.daddr;
        bus.i_DHB   = ~v.dhb;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bus.o_IGNT || bus.o_DGNT) && cyc < 20);
        chk($sformatf("v%0d grant_latency", k), 32'(cyc), 32'd3);
        chk($sformatf("v%0d ignt", k), 32'(bus.o_IGNT), 32'(v.exp_i));
        chk($sformatf("v%0d dgnt", k), 32'(bus.o_DGNT), 32'(!v.exp_i));
        chk($sformatf("v%0d err", k), 32'(bus.o_ERR), 32'h0);
        chk($sformatf("v%0d rdata", k), v.exp_i ? bus.o_IRDATA : bus.o_DRDATA, v.mdata);
        bus.i_IREQ = 1'b0;
        bus.i_DREQ = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d gnt_drop", k), 32'({bus.o_IGNT, bus.o_DGNT}), 32'h0);
        chk($sformatf("v%0d rdata_hold", k), v.exp_i ? bus.o_IRDATA : bus.o_DRDATA, v.mdata);
    endtask

    initial begin
        int cyc;
        int ngr;
        int last_t;
        int pulses;
        logic [3:0] tie_exp_d;

        bus.i_IREQ = 1'b0; bus.i_DREQ = 1'b0;
        bus.i_IADDR = 32'h0; bus.i_DADDR = 32'h0; bus.i_DHB = 2'b00;

        //                ireq  dreq  iaddr         daddr         dhb    mdata         exp_i addr          hb
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0999, 2'b00, 32'h0000_0513, 1'b1, 32'h0000_0010, 2'b10};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0023, 2'b00, 32'h0000_00AB, 1'b0, 32'h0000_0023, 2'b00};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0102, 2'b01, 32'h0000_BEEF, 1'b0, 32'h0000_0102, 2'b01};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_2000, 2'b10, 32'h1234_5678, 1'b0, 32'h0000_2000, 2'b10};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 2'b01, 32'hDEAD_BEEF, 1'b1, 32'hFFFF_FFFC, 2'b10};
        // Tie after an I grant: data wins under both policies
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0044, 32'h0000_0088, 2'b00, 32'h0000_005A, 1'b0, 32'h0000_0088, 2'b00};

`ifdef ARB_ROUND_ROBIN_EN
        tie_exp_d = 4'b1010;  // index 0 first: I, D, I, D
`else
        tie_exp_d = 4'b1111;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst mem_req", 32'(bus.o_MEM_REQ), 32'h0);
        chk("rst mem_ce", 32'(bus.o_MEM_CE), 32'h0);
        chk("rst gnts", 32'({bus.o_IGNT, bus.o_DGNT, bus.o_ERR}), 32'h0);
        chk("rst irdata", bus.o_IRDATA, 32'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // Tie held for four transactions, then D drops and I is served
        @(negedge clk);
        mem_data = 32'h0A0A_0A0A;
        bus.i_IADDR = 32'h100; bus.i_DADDR = 32'h200; bus.i_DHB = 2'b10;
        bus.i_IREQ = 1'b1; bus.i_DREQ = 1'b1;
        ngr = 0; last_t = 0; pulses = 0; cyc = 0;
        while (ngr < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.o_MEM_REQ) pulses++;
            if (bus.o_IGNT || bus.o_DGNT) begin
                chk($sformatf("tie%0d dgnt", ngr), 32'(bus.o_DGNT), 32'(tie_exp_d[ngr]));
                chk($sformatf("tie%0d ignt", ngr), 32'(bus.o_IGNT), 32'(!tie_exp_d[ngr]));
                if (ngr > 0) chk($sformatf("tie%0d period", ngr), 32'(cyc - last_t), 32'd4);
                last_t = cyc;
                ngr++;
            end
        end
        chk("tie grant_count", 32'(ngr), 32'd4);
        chk("tie mem_req_pulses", 32'(pulses), 32'd4);
        bus.i_DREQ = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bus.o_IGNT || bus.o_DGNT) && cyc < 20);
        chk("tie_after ignt", 32'(bus.o_IGNT), 32'h1);
        chk("tie_after dgnt", 32'(bus.o_DGNT), 32'h0);
        chk("tie_after period", 32'(cyc), 32'd4);
        bus.i_IREQ = 1'b0;
        @(negedge clk);

        // Timeout: memory never grants
        @(negedge clk);
        mem_auto = 1'b0;
        mem_data = 32'hFFFF_FFFF;
        bus.i_DADDR = 32'h40; bus.i_DHB = 2'b00; bus.i_DREQ = 1'b1;
        wait_issue("to issue");
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bus.o_IGNT || bus.o_DGNT) && cyc < 40);
        chk("to cycles", 32'(cyc), 32'd16);
        chk("to dgnt", 32'(bus.o_DGNT), 32'h1);
        chk("to ignt", 32'(bus.o_IGNT), 32'h0);
        chk("to err", 32'(bus.o_ERR), 32'h1);
        chk("to drdata", bus.o_DRDATA, 32'h0);
        bus.i_DREQ = 1'b0;
        mem_auto = 1'b1;
        @(negedge clk);
        chk("to err_drop", 32'(bus.o_ERR), 32'h0);
        run_vec(vecs[1], 6);

        // Reset asserted mid-WAIT clears outputs immediately
        @(negedge clk);
        mem_auto = 1'b0;
        bus.i_IADDR = 32'h80; bus.i_IREQ = 1'b1;
        wait_issue("rw issue");
        @(negedge clk);
        chk("rw ce_in_wait", 32'(bus.o_MEM_CE), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw mem_ce", 32'(bus.o_MEM_CE), 32'h0);
        chk("rw mem_addr", bus.o_MEM_ADDR, 32'h0);
        chk("rw gnts", 32'({bus.o_IGNT, bus.o_DGNT, bus.o_ERR, bus.o_MEM_REQ}), 32'h0);
        chk("rw irdata", bus.o_IRDATA, 32'h0);
        chk("rw drdata", bus.o_DRDATA, 32'h0);
        bus.i_IREQ = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_auto = 1'b1;
        @(negedge clk);
        gnt_force = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stray%0d gnts", k), 32'({bus.o_IGNT, bus.o_DGNT, bus.o_ERR}), 32'h0);
            chk($sformatf("stray%0d mem_req", k), 32'(bus.o_MEM_REQ), 32'h0);
        end
        gnt_force = 1'b0;
        run_vec(vecs[0], 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
